// File: rtl/ramp_pkg.sv
// Shared types for the ramp envelope generator: FSM states, accumulator
// operations and full-scale constant helpers.
package ramp_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UP   = 3'd1,
        HOLD = 3'd2,
        DOWN = 3'd3,
        DONE = 3'd4
    } ramp_state_t;

    typedef enum logic [2:0] {
        ACC_KEEP,
        ACC_ADD,
        ACC_SUB,
        ACC_MAX,
        ACC_ZERO
    } acc_op_t;

    // All-ones value of the given width, right-aligned in 64 bits.
    function automatic logic [63:0] full_scale(input int unsigned width);
        if (width >= 64) return '1;
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/ramp_envelope_gen_if.sv
// Control and status bundle between the PS slice logic and one
// ramp_envelope_gen channel.
interface ramp_envelope_gen_if #(
    parameter int ACC_WIDTH      = 32,
    parameter int FACTOR_WIDTH   = 16,
    parameter int HOLD_CNT_WIDTH = 32
) ();

    logic                      enable_ramping;
    logic                      start_ramp_down;
    logic                      trigger;
    logic [ACC_WIDTH-1:0]      ramp_step;
    logic [HOLD_CNT_WIDTH-1:0] hold_cycles;
    logic [FACTOR_WIDTH-1:0]   ramp_factor;
    logic                      ramping_up;
    logic                      ramping_down;
    logic                      ramp_done;

    modport master (
        output enable_ramping, start_ramp_down, trigger,
        output ramp_step, hold_cycles,
        input  ramp_factor, ramping_up, ramping_down, ramp_done
    );

    modport slave (
        input  enable_ramping, start_ramp_down, trigger,
        input  ramp_step, hold_cycles,
        output ramp_factor, ramping_up, ramping_down, ramp_done
    );

endinterface

// File: rtl/ramp_sat_accum.sv
// Saturating up/down accumulator; reports whether the pending add or
// subtract would clamp so the FSM can change state in the same cycle.
module ramp_sat_accum
    import ramp_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  acc_op_t              op,
    input  logic [WIDTH-1:0]     step,
    output logic                 add_full,
    output logic                 sub_empty,
    output logic [OUT_WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(full_scale(WIDTH));

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    // A zero step clamps immediately rather than stalling the ramp.
    assign sum       = {1'b0, acc} + {1'b0, step};
    assign diff      = {1'b0, acc} - {1'b0, step};
    assign add_full  = sum[WIDTH] | (sum[WIDTH-1:0] == MAX) | (step == '0);
    assign sub_empty = diff[WIDTH] | (diff[WIDTH-1:0] == '0) | (step == '0);
    assign value     = acc[WIDTH-1 -: OUT_WIDTH];

    always_comb begin
        acc_next = acc;
        unique case (op)
            ACC_ADD:  acc_next = add_full ? MAX : sum[WIDTH-1:0];
            ACC_SUB:  acc_next = sub_empty ? '0 : diff[WIDTH-1:0];
            ACC_MAX:  acc_next = MAX;
            ACC_ZERO: acc_next = '0;
            default:  acc_next = acc;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) acc <= '0;
        else          acc <= acc_next;
    end

endmodule

// File: rtl/ramp_envelope_gen.sv
// Per-channel linear ramp up / hold / ramp down envelope for DAC scaling.
// Optional auto ramp-down after a hold delay: define RAMP_HOLD_TIMER_EN.
module ramp_envelope_gen
    import ramp_pkg::*;
#(
    parameter int ACC_WIDTH      = 32,
    parameter int FACTOR_WIDTH   = 16,
    parameter int HOLD_CNT_WIDTH = 32
) (
    input  logic          clk,
    input  logic          aresetn,
    ramp_envelope_gen_if.slave bus
);

    localparam logic [FACTOR_WIDTH-1:0] FACTOR_MAX =
        FACTOR_WIDTH'(full_scale(FACTOR_WIDTH));

    ramp_state_t            state;
    ramp_state_t            state_next;
    acc_op_t                op;
    logic [ACC_WIDTH-1:0]   step_q;
    logic                   latch_step;
    logic                   trigger_d;
    logic                   rise;
    logic                   add_full;
    logic                   sub_empty;
    logic [FACTOR_WIDTH-1:0] value;
    logic                   hold_load;
    logic                   hold_expired;
    logic                   status_up;
    logic                   status_down;
    logic                   status_done;

    assign rise = bus.trigger & ~trigger_d;

    ramp_sat_accum #(
        .WIDTH     (ACC_WIDTH),
        .OUT_WIDTH (FACTOR_WIDTH)
    ) u_accum (
        .clk       (clk),
        .aresetn   (aresetn),
        .op        (op),
        .step      (step_q),
        .add_full  (add_full),
        .sub_empty (sub_empty),
        .value     (value)
    );

`ifdef RAMP_HOLD_TIMER_EN
    logic [HOLD_CNT_WIDTH-1:0] hold_cnt;

    // Zero and one both give a single HOLD cycle.
    assign hold_expired = (hold_cnt <= HOLD_CNT_WIDTH'(1));

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            hold_cnt <= '0;
        end else if (hold_load) begin
            hold_cnt <= bus.hold_cycles;
        end else if (state == HOLD && hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_CNT_WIDTH'(1);
        end
    end
`else
    logic [HOLD_CNT_WIDTH-1:0] unused_hold_cycles;
    logic                      unused_hold_load;

    assign hold_expired       = 1'b0;
    assign unused_hold_cycles = bus.hold_cycles;
    assign unused_hold_load   = hold_load;
`endif

    always_comb begin
        state_next = state;
        op         = ACC_KEEP;
        latch_step = 1'b0;
        hold_load  = 1'b0;
        if (!bus.enable_ramping) begin
            state_next = IDLE;
            op         = ACC_MAX;
        end else begin
            unique case (state)
                IDLE: begin
                    op = ACC_ZERO;
                    if (rise) begin
                        state_next = UP;
                        latch_step = 1'b1;
                    end
                end
                UP: begin
                    // Abort holds acc this cycle; DOWN starts from here.
                    if (bus.start_ramp_down) begin
                        state_next = DOWN;
                        latch_step = 1'b1;
                    end else begin
                        op = ACC_ADD;
                        if (add_full) begin
                            state_next = HOLD;
                            hold_load  = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    op = ACC_MAX;
                    if (bus.start_ramp_down || hold_expired) begin
                        state_next = DOWN;
                        latch_step = 1'b1;
                    end
                end
                DOWN: begin
                    op = ACC_SUB;
                    if (sub_empty) state_next = DONE;
                end
                DONE: begin
                    op = ACC_ZERO;
                    if (!bus.trigger && !bus.start_ramp_down) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    op         = ACC_ZERO;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            step_q      <= '0;
            trigger_d   <= 1'b0;
            status_up   <= 1'b0;
            status_down <= 1'b0;
            status_done <= 1'b0;
        end else begin
            state       <= state_next;
            trigger_d   <= bus.trigger;
            status_up   <= (state_next == UP);
            status_down <= (state_next == DOWN);
            status_done <= (state_next == DONE);
            if (latch_step) step_q <= bus.ramp_step;
        end
    end

    assign bus.ramp_factor  = aresetn ? value : FACTOR_MAX;
    assign bus.ramping_up   = status_up;
    assign bus.ramping_down = status_down;
    assign bus.ramp_done    = status_done;

endmodule
